// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I instruction-fetch stage: PC, ROM address, IF/ID register, trap on bad PC
module inst_fetch #(
  parameter logic [31:0] P_RESET_PC  = 32'h0000_0000,
  parameter int          P_ROM_DEPTH = 64,
  parameter logic [31:0] P_NOP       = 32'h0000_0013
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStall,
  input  logic        iFlush,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic [31:0] oRomAddr,
  input  logic [31:0] iRomData,
  output logic [31:0] oIfIdPc,
  output logic [31:0] oIfIdPcPlus4,
  output logic [31:0] oIfIdInst,
  output logic        oIfIdValid,
  output logic        oTrap,
  output logic [31:0] oFetchCnt
);

  // First byte address past the end of the instruction ROM.
  localparam logic [31:0] ROM_LIMIT = 32'(P_ROM_DEPTH) << 2;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_TRAP  = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] ifid_pc_next;
  logic [31:0] ifid_pc_plus4_next;
  logic [31:0] ifid_inst_next;
  logic        ifid_valid_next;
  logic [31:0] fetch_cnt_next;
  logic        redirect_bad;
  logic        pc_out_of_range;

  assign pc_plus4        = pc + 32'd4;
  assign pc_out_of_range = (pc >= ROM_LIMIT);
  assign redirect_bad    = (iRedirectPc[1:0] != 2'b00) || (iRedirectPc >= ROM_LIMIT);

  // The ROM is addressed straight from the PC register.
  assign oRomAddr = pc;

  // State register; only reset leaves TRAP.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and next-datapath selection; rules are checked in priority order.
  always_comb begin
    next_state         = state;
    pc_next            = pc;
    ifid_pc_next       = oIfIdPc;
    ifid_pc_plus4_next = oIfIdPcPlus4;
    ifid_inst_next     = oIfIdInst;
    ifid_valid_next    = oIfIdValid;
    fetch_cnt_next     = oFetchCnt;

    if (state == S_FETCH) begin
      if (iRedirect && redirect_bad) begin
        next_state      = S_TRAP;
        ifid_inst_next  = P_NOP;
        ifid_valid_next = 1'b0;
      end else if (iRedirect) begin
        // A redirect overrides a stall: the wrong-path fetch must be dropped.
        pc_next         = iRedirectPc;
        ifid_inst_next  = P_NOP;
        ifid_valid_next = 1'b0;
      end else if (iStall) begin
        // Hold everything; a pending flush is deliberately ignored here.
        pc_next = pc;
      end else if (pc_out_of_range) begin
        next_state      = S_TRAP;
        ifid_inst_next  = P_NOP;
        ifid_valid_next = 1'b0;
      end else if (iFlush) begin
        pc_next         = pc_plus4;
        ifid_inst_next  = P_NOP;
        ifid_valid_next = 1'b0;
      end else begin
        pc_next            = pc_plus4;
        ifid_pc_next       = pc;
        ifid_pc_plus4_next = pc_plus4;
        ifid_inst_next     = iRomData;
        ifid_valid_next    = 1'b1;
        fetch_cnt_next     = oFetchCnt + 32'd1;
      end
    end
  end

  // PC, IF/ID pipeline register, trap flag and fetch counter.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pc           <= P_RESET_PC;
      oIfIdPc      <= 32'd0;
      oIfIdPcPlus4 <= 32'd4;
      oIfIdInst    <= P_NOP;
      oIfIdValid   <= 1'b0;
      oTrap        <= 1'b0;
      oFetchCnt    <= 32'd0;
    end else begin
      pc           <= pc_next;
      oIfIdPc      <= ifid_pc_next;
      oIfIdPcPlus4 <= ifid_pc_plus4_next;
      oIfIdInst    <= ifid_inst_next;
      oIfIdValid   <= ifid_valid_next;
      oTrap        <= (next_state == S_TRAP);
      oFetchCnt    <= fetch_cnt_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        trap;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  inst_fetch dut (
    .iClk         (clk),
    .iRst         (rst),
    .iStall       (stall),
    .iFlush       (flush),
    .iRedirect    (redirect),
    .iRedirectPc  (redirect_pc),
    .oRomAddr     (rom_addr),
    .iRomData     (rom_data),
    .oIfIdPc      (ifid_pc),
    .oIfIdPcPlus4 (ifid_pc_plus4),
    .oIfIdInst    (ifid_inst),
    .oIfIdValid   (ifid_valid),
    .oTrap        (trap),
    .oFetchCnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  // ROM model: word at byte address a is 0xA500_0000 | a; beyond the ROM reads all ones.
  assign rom_data = (rom_addr < 32'h100) ? (32'hA500_0000 | rom_addr) : 32'hFFFF_FFFF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_addr", rom_addr, 32'h0);
    check_eq("rst_ifid_pc", ifid_pc, 32'h0);
    check_eq("rst_pc4", ifid_pc_plus4, 32'h4);
    check_eq("rst_inst", ifid_inst, 32'h13);
    check_eq("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("rst_trap", {31'd0, trap}, 32'd0);
    check_eq("rst_cnt", fetch_cnt, 32'd0);

    // Free run
    step();
    check_eq("run1_addr", rom_addr, 32'h4);
    check_eq("run1_ifid_pc", ifid_pc, 32'h0);
    check_eq("run1_inst", ifid_inst, 32'hA500_0000);
    check_eq("run1_valid", {31'd0, ifid_valid}, 32'd1);
    check_eq("run1_cnt", fetch_cnt, 32'd1);
    step();
    check_eq("run2_addr", rom_addr, 32'h8);
    check_eq("run2_inst", ifid_inst, 32'hA500_0004);
    check_eq("run2_pc4", ifid_pc_plus4, 32'h8);

    // Stall three cycles at PC=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_addr", rom_addr, 32'h8);
      check_eq("stall_ifid_pc", ifid_pc, 32'h4);
      check_eq("stall_cnt", fetch_cnt, 32'd2);
    end
    stall = 1'b0;
    step();
    check_eq("unstall_addr", rom_addr, 32'hC);
    check_eq("unstall_ifid_pc", ifid_pc, 32'h8);
    check_eq("unstall_inst", ifid_inst, 32'hA500_0008);
    step();
    check_eq("run5_addr", rom_addr, 32'h10);
    check_eq("run5_cnt", fetch_cnt, 32'd4);

    // Redirect at PC=16 to 0x28
    redirect = 1'b1; redirect_pc = 32'h28;
    step();
    redirect = 1'b0;
    check_eq("redir_addr", rom_addr, 32'h28);
    check_eq("redir_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("redir_inst", ifid_inst, 32'h13);
    check_eq("redir_ifid_pc_hold", ifid_pc, 32'hC);
    check_eq("redir_pc4_hold", ifid_pc_plus4, 32'h10);
    check_eq("redir_cnt", fetch_cnt, 32'd4);
    step();
    check_eq("post_redir_ifid_pc", ifid_pc, 32'h28);
    check_eq("post_redir_pc4", ifid_pc_plus4, 32'h2C);
    check_eq("post_redir_inst", ifid_inst, 32'hA500_0028);
    check_eq("post_redir_valid", {31'd0, ifid_valid}, 32'd1);
    check_eq("post_redir_cnt", fetch_cnt, 32'd5);

    // Redirect together with stall: redirect wins
    redirect = 1'b1; redirect_pc = 32'h4; stall = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0;
    check_eq("rs_addr", rom_addr, 32'h4);
    check_eq("rs_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("rs_cnt", fetch_cnt, 32'd5);

    // Flush in a normal cycle
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_addr", rom_addr, 32'h8);
    check_eq("flush_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("flush_inst", ifid_inst, 32'h13);
    check_eq("flush_ifid_pc_hold", ifid_pc, 32'h28);
    check_eq("flush_cnt", fetch_cnt, 32'd5);
    step();
    check_eq("post_flush_ifid_pc", ifid_pc, 32'h8);
    check_eq("post_flush_cnt", fetch_cnt, 32'd6);

    // Flush while stalled is ignored
    stall = 1'b1; flush = 1'b1;
    step();
    stall = 1'b0; flush = 1'b0;
    check_eq("sf_addr", rom_addr, 32'hC);
    check_eq("sf_valid", {31'd0, ifid_valid}, 32'd1);
    check_eq("sf_inst", ifid_inst, 32'hA500_0008);

    // Misaligned redirect -> TRAP; further redirects ignored
    redirect = 1'b1; redirect_pc = 32'h2A;
    step();
    check_eq("mis_trap", {31'd0, trap}, 32'd1);
    check_eq("mis_addr", rom_addr, 32'hC);
    check_eq("mis_valid", {31'd0, ifid_valid}, 32'd0);
    redirect_pc = 32'h4;
    step();
    redirect = 1'b0;
    check_eq("trap_hold", {31'd0, trap}, 32'd1);
    check_eq("trap_hold_addr", rom_addr, 32'hC);
    check_eq("trap_hold_cnt", fetch_cnt, 32'd6);
    do_reset();
    check_eq("trap_rst_addr", rom_addr, 32'h0);
    check_eq("trap_rst_trap", {31'd0, trap}, 32'd0);
    check_eq("trap_rst_cnt", fetch_cnt, 32'd0);

    // Aligned but out-of-range redirect target -> TRAP
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check_eq("oor_redir_trap", {31'd0, trap}, 32'd1);
    check_eq("oor_redir_addr", rom_addr, 32'h0);

    // Last legal redirect target
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFC;
    step();
    redirect = 1'b0;
    check_eq("last_redir_addr", rom_addr, 32'hFC);
    check_eq("last_redir_trap", {31'd0, trap}, 32'd0);

    // Free run off the end of the ROM
    do_reset();
    for (int i = 0; i < 63; i++) step();
    check_eq("end63_addr", rom_addr, 32'hFC);
    check_eq("end63_ifid_pc", ifid_pc, 32'hF8);
    check_eq("end63_cnt", fetch_cnt, 32'd63);
    step();
    check_eq("end64_addr", rom_addr, 32'h100);
    check_eq("end64_ifid_pc", ifid_pc, 32'hFC);
    check_eq("end64_inst", ifid_inst, 32'hA500_00FC);
    check_eq("end64_cnt", fetch_cnt, 32'd64);
    check_eq("end64_trap", {31'd0, trap}, 32'd0);
    stall = 1'b1;
    step();
    stall = 1'b0;
    check_eq("end_stall_trap", {31'd0, trap}, 32'd0);
    check_eq("end_stall_addr", rom_addr, 32'h100);
    step();
    check_eq("end_trap", {31'd0, trap}, 32'd1);
    check_eq("end_trap_valid", {31'd0, ifid_valid}, 32'd0);
    check_eq("end_trap_inst", ifid_inst, 32'h13);
    check_eq("end_trap_ifid_pc", ifid_pc, 32'hFC);
    check_eq("end_trap_cnt", fetch_cnt, 32'd64);
    step();
    check_eq("end_trap2_addr", rom_addr, 32'h100);
    check_eq("end_trap2", {31'd0, trap}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
